e203_exu_wbck_arb: RTL
======================

// Module: e203_exu_wbck_arb
// PURPOSE
//  Writeback arbiter directly upstream of the integer regfile write port.
//  Merges single-cycle ALU results and long-pipe results (LSU/MULDIV) into the single
//  regfile write port (ena/idx/dat).
//  Long-pipe results are buffered in a small FIFO so the long pipe is not back-pressured
//  by ALU traffic; buffered results win arbitration by default.
// PARAMETERS
//  XLEN         32  data width of a writeback result
//  RFIDX_W      5   register index width
//  LONGP_DEPTH  2   long-pipe result FIFO entries (>=1, power of 2)
//  STARVE_MAX   4   ALU stall cycles before forced ALU grant (only with E203_WBCK_STARVE_GUARD_EN)
// PORTS
//  clk               in   1        core clock; all state updates on rising edge
//  rst               in   1        synchronous reset, active-high
//  alu_wbck_valid    in   1        ALU result valid
//  alu_wbck_ready    out  1        ALU result accepted this cycle
//  alu_wbck_idx      in   RFIDX_W  ALU destination register
//  alu_wbck_dat      in   XLEN     ALU result
//  longp_wbck_valid  in   1        long-pipe result valid
//  longp_wbck_ready  out  1        long-pipe result accepted (FIFO not full)
//  longp_wbck_idx    in   RFIDX_W  long-pipe destination register
//  longp_wbck_dat    in   XLEN     long-pipe result
//  longp_wbck_err    in   1        result is faulting: retire the entry, no regfile write
//  rf_wbck_ena       out  1        regfile write enable
//  rf_wbck_idx       out  RFIDX_W  regfile write index
//  rf_wbck_dat       out  XLEN     regfile write data
//  longp_pend_cnt    out  $clog2(LONGP_DEPTH+1)  FIFO occupancy (registered)
// BEHAVIOUR
//  - Reset (rst high at an edge): FIFO rd/wr pointers and count -> 0, starve counter -> 0.
//    While rst is high: rf_wbck_ena=0, alu_wbck_ready=0, longp_wbck_ready=0.
//    Reset mid-operation discards all buffered entries; none are written.
//  - FIFO entry = {err, idx, dat}. longp_wbck_ready = !full, taken from the registered
//    count only. No push while full, even if a pop happens in the same cycle.
//    Push on longp_wbck_valid & longp_wbck_ready.
//    Pointers wrap modulo LONGP_DEPTH. Simultaneous push+pop keeps the count unchanged.
//  - Long-pipe latency: an entry is visible at the FIFO head the cycle after its push.
//    Minimum push-to-write = 1 cycle. No same-cycle bypass.
//  - Arbitration (combinational, per cycle):
//    - FIFO non-empty and no forced ALU grant: grant head, alu_wbck_ready=0, pop head.
//    - Otherwise: alu_wbck_ready=1 (outside reset), and the ALU is selected.
//  - Output:
//    - Head granted: rf_wbck_ena = !head.err, with idx/dat from the head.
//    - ALU selected: rf_wbck_ena = alu_wbck_valid, with ALU idx/dat.
//    - idx=0 is passed through unchanged; the regfile discards x0 writes.
//    - A popped err entry consumes the write slot with ena=0.
//  - rf_wbck_idx and rf_wbck_dat are don't-care when rf_wbck_ena=0.
//    They are driven from the selected source, with no extra gating.
//  - The regfile always accepts writes, so grant == pop / handshake; there is no output ready.
// CONFIGURATION
//  E203_WBCK_STARVE_GUARD_EN defined:
//    - starve_cnt (width $clog2(STARVE_MAX+1)) increments, saturating, in each cycle
//      with alu_wbck_valid & !alu_wbck_ready.
//    - When starve_cnt==STARVE_MAX and alu_wbck_valid, the ALU is granted that cycle and
//      the FIFO does not pop.
//    - The counter clears on any cycle where the ALU handshakes, or when alu_wbck_valid=0.
//  Not defined: strict long-pipe priority, no counter logic.
// STRUCTURE
//  - Package e203_wbck_pkg holds the wbck_entry_t typedef {err, idx, dat} and the default
//    XLEN, RFIDX_W, LONGP_DEPTH and STARVE_MAX constants.
//  - Sub-module e203_wbck_longp_fifo: parameterised synchronous FIFO with push/pop, full,
//    empty and count outputs, and synchronous active-high reset.
//  - The top level holds the arbiter, the optional starve counter and the output mux.
// TESTING
//  1. ALU only: alu valid idx=5 dat=0x1234, FIFO empty.
//     -> same cycle alu_ready=1, rf ena=1 idx=5 dat=0x1234.
//  2. Long-pipe write: longp valid idx=7 dat=0xDEAD at cycle N.
//     -> cycle N+1 rf ena=1 idx=7 dat=0xDEAD; longp_pend_cnt 1 -> 0 at N+2.
//  3. Contention, macro off: ALU valid idx=3 held continuously while 2 longp results
//     are pushed back-to-back.
//     -> alu_ready=0 for 2 cycles, longp written in push order, ALU written on the 3rd cycle.
//  4. Full FIFO: 3 longp pushes in consecutive cycles, with the ALU granted via starve,
//     DEPTH=2.
//     -> longp_ready=0 after the 2nd push, 3rd held until the count drops; no entry lost
//     or duplicated.
//  5. Err entry: longp err=1 idx=9 pushed.
//     -> next cycle FIFO pops, rf ena=0, ALU blocked that cycle.
//  6. Starve guard on, STARVE_MAX=4: saturate FIFO traffic with ALU valid.
//     -> ALU granted on the 5th stalled cycle, counter back to 0.
//  7. Reset mid-operation: rst=1 with 2 entries queued.
//     -> next cycle pend_cnt=0; no rf write of the dropped entries after rst falls.

Source files
------------

// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared writeback types and default sizing for the writeback arbiter slice.
// Entry layout {err, idx, dat} is the long-pipe FIFO payload.
package e203_wbck_pkg;

  localparam int XLEN        = 32;
  localparam int RFIDX_W     = 5;
  localparam int LONGP_DEPTH = 2;
  localparam int STARVE_MAX  = 4;

  typedef struct packed {
    logic               err;
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } wbck_entry_t;

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Writeback bundle: ALU and long-pipe producers in, regfile write port out.
// Producers/bench use master, the arbiter uses slave.
interface e203_exu_wbck_arb_if
  import e203_wbck_pkg::*;
#(
  parameter int XLEN        = e203_wbck_pkg::XLEN,
  parameter int RFIDX_W     = e203_wbck_pkg::RFIDX_W,
  parameter int LONGP_DEPTH = e203_wbck_pkg::LONGP_DEPTH
);
  localparam int CW = $clog2(LONGP_DEPTH + 1);

  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_dat;

  logic               longp_wbck_valid;
  logic               longp_wbck_ready;
  logic [RFIDX_W-1:0] longp_wbck_idx;
  logic [XLEN-1:0]    longp_wbck_dat;
  logic               longp_wbck_err;

  logic               rf_wbck_ena;
  logic [RFIDX_W-1:0] rf_wbck_idx;
  logic [XLEN-1:0]    rf_wbck_dat;
  logic [CW-1:0]      longp_pend_cnt;

  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    input  alu_wbck_ready,
    output longp_wbck_valid, longp_wbck_idx,
    output longp_wbck_dat, longp_wbck_err,
    input  longp_wbck_ready,
    input  rf_wbck_ena, rf_wbck_idx, rf_wbck_dat,
    input  longp_pend_cnt
  );

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    output alu_wbck_ready,
    input  longp_wbck_valid, longp_wbck_idx,
    input  longp_wbck_dat, longp_wbck_err,
    output longp_wbck_ready,
    output rf_wbck_ena, rf_wbck_idx, rf_wbck_dat,
    output longp_pend_cnt
  );

endinterface

// File: rtl/e203_exu_wbck_arb_fifo.sv
// Long-pipe result FIFO: synchronous, active-high reset, registered count.
// Push is refused while full even if a pop happens in the same cycle.
module e203_wbck_longp_fifo
  import e203_wbck_pkg::*;
#(
  parameter int W     = 1 + RFIDX_W + XLEN,
  parameter int DEPTH = LONGP_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop)  rptr <= inc(rptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Writeback arbiter: buffered long-pipe results beat ALU results.
// E203_WBCK_STARVE_GUARD_EN adds a forced ALU grant after STARVE_MAX stalls.
module e203_exu_wbck_arb
  import e203_wbck_pkg::*;
#(
  parameter int XLEN        = e203_wbck_pkg::XLEN,
  parameter int RFIDX_W     = e203_wbck_pkg::RFIDX_W,
  parameter int LONGP_DEPTH = e203_wbck_pkg::LONGP_DEPTH
`ifdef E203_WBCK_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX  = e203_wbck_pkg::STARVE_MAX
`endif
) (
  input logic clk,
  input logic rst,
  e203_exu_wbck_arb_if.slave wb
);
  localparam int EW = 1 + RFIDX_W + XLEN;
  localparam int CW = $clog2(LONGP_DEPTH + 1);

  logic [EW-1:0]      push_ent;
  logic [EW-1:0]      head_ent;
  logic               head_err;
  logic [RFIDX_W-1:0] head_idx;
  logic [XLEN-1:0]    head_dat;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic               force_alu;
  logic               grant_head;

  assign push_ent = {wb.longp_wbck_err,
                     wb.longp_wbck_idx,
                     wb.longp_wbck_dat};
  assign {head_err, head_idx, head_dat} = head_ent;

  e203_wbck_longp_fifo #(
    .W     (EW),
    .DEPTH (LONGP_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wb.longp_wbck_valid && wb.longp_wbck_ready),
    .wdata (push_ent),
    .pop   (grant_head),
    .rdata (head_ent),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef E203_WBCK_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  assign force_alu = wb.alu_wbck_valid
                   && (starve_cnt == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!wb.alu_wbck_valid || wb.alu_wbck_ready)
      starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_alu = 1'b0;
`endif

  assign grant_head          = !rst && !empty && !force_alu;
  assign wb.alu_wbck_ready   = !rst && !grant_head;
  assign wb.longp_wbck_ready = !rst && !full;
  assign wb.longp_pend_cnt   = count;

  always_comb begin
    wb.rf_wbck_ena = 1'b0;
    wb.rf_wbck_idx = wb.alu_wbck_idx;
    wb.rf_wbck_dat = wb.alu_wbck_dat;
    unique case (1'b1)
      rst: wb.rf_wbck_ena = 1'b0;
      grant_head: begin
        wb.rf_wbck_ena = !head_err;
        wb.rf_wbck_idx = head_idx;
        wb.rf_wbck_dat = head_dat;
      end
      default: wb.rf_wbck_ena = wb.alu_wbck_valid;
    endcase
  end

endmodule
